set_timed_injector: RTL and testbench

SET_TIMED_INJECTOR -- requirements
Module: set_timed_injector

---
 rtl/set_injector_pkg.sv | 43 ++++
 rtl/set_injector_channel.sv | 69 ++++++
 rtl/set_timed_injector.sv | 95 +++++++++
 tb/tb_set_timed_injector.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/set_injector_pkg.sv
// set_injector_pkg: channel states, command opcodes/keywords and numeric string parsers
// shared by the set_timed_injector top and its per-channel sub-module.
package set_injector_pkg;

    typedef enum logic [1:0] {IDLE, DELAY, PULSE} state_e;
    typedef enum logic [1:0] {OP_SET, OP_DELAY, OP_PULSE} op_e;

    localparam string KW_SET       = "SET";
    localparam string KW_SET_DELAY = "SET_DELAY";
    localparam string KW_PULSE     = "PULSE";

    function automatic logic [7:0] digit(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) ? c - 8'd48 :
               (c >= 8'h61 && c <= 8'h66) ? c - 8'd87 :
               (c >= 8'h41 && c <= 8'h46) ? c - 8'd55 : 8'd0;
    endfunction

    // Wraps modulo 2^64 so callers can keep the low bits they need.
    function automatic logic [63:0] parse_num(input string s, input int start, input logic [63:0] base);
        logic [63:0] acc;
        acc = '0;
        for (int i = start; i < s.len(); i++)
            acc = acc * base + {56'd0, digit(s[i])};
        return acc;
    endfunction

    function automatic logic [63:0] parse_value(input string s);
        return (s.len() > 1 && s[0] == 8'h30 && (s[1] == 8'h78 || s[1] == 8'h58)) ?
               parse_num(s, 2, 64'd16) : parse_num(s, 0, 64'd10);
    endfunction

    // Clamping at every step keeps long digit strings from wrapping past the limit.
    function automatic logic [63:0] parse_dec_sat(input string s, input logic [63:0] max);
        logic [63:0] acc;
        acc = '0;
        for (int i = 0; i < s.len(); i++) begin
            acc = acc * 64'd10 + {56'd0, digit(s[i])};
            if (acc > max) acc = max;
        end
        return acc;
    endfunction

endpackage

// File: rtl/set_injector_channel.sv
// set_injector_channel: one output channel with IDLE/DELAY/PULSE timer FSM; hold_q carries
// the pending value in DELAY and the value to restore in PULSE.
module set_injector_channel
    import set_injector_pkg::*;
#(
    parameter int SET_WIDTH = 32,
    parameter int CNT_WIDTH = 16,
    parameter logic [SET_WIDTH-1:0] RST_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_cmd,
    input  op_e                  i_op,
    input  logic [SET_WIDTH-1:0] i_val,
    input  logic [CNT_WIDTH-1:0] i_cnt,
    output logic [SET_WIDTH-1:0] o_val,
    output logic                 o_busy
);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [SET_WIDTH-1:0] val_q, val_d, hold_q, hold_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        hold_d  = hold_q;
        if (state_q != IDLE) cnt_d = cnt_q - CNT_WIDTH'(1);
        if (state_q != IDLE && cnt_q == CNT_WIDTH'(1)) begin
            state_d = IDLE;
            val_d   = hold_q;
        end
        // A new command overrides any timer expiry in the same cycle.
        if (i_cmd && (i_op == OP_SET || (i_op == OP_DELAY && i_cnt == '0))) begin
            state_d = IDLE;
            cnt_d   = '0;
            val_d   = i_val;
        end else if (i_cmd && i_op == OP_DELAY) begin
            state_d = DELAY;
            cnt_d   = i_cnt;
            val_d   = val_q;
            hold_d  = i_val;
        end else if (i_cmd && i_op == OP_PULSE && i_cnt != '0) begin
            state_d = PULSE;
            cnt_d   = i_cnt;
            val_d   = i_val;
            hold_d  = val_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            val_q   <= RST_VAL;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            hold_q  <= hold_d;
        end
    end

    assign o_val  = val_q;
    assign o_busy = state_q != IDLE;

endmodule

// File: rtl/set_timed_injector.sv
// set_timed_injector: decodes string commands (SET / SET_DELAY / PULSE) onto named channels.
// Define SET_TIMED_INJECTOR_LOG_EN to log channel updates and rejected commands.
module set_timed_injector
    import set_injector_pkg::*;
#(
    parameter int ARGS_NB   = 5,
    parameter int SET_SIZE  = 5,
    parameter int SET_WIDTH = 32,
    parameter int CNT_WIDTH = 16,
    parameter logic [SET_WIDTH-1:0] RST_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  string                i_set_alias [SET_SIZE],
    input  logic                 i_set_sel,
    input  logic                 i_args_valid,
    input  string                i_args [ARGS_NB],
    output logic [SET_WIDTH-1:0] o_set [SET_SIZE],
    output logic [SET_SIZE-1:0]  o_busy,
    output logic                 o_ack,
    output logic                 o_err
);

    localparam logic [63:0] CNT_MAX = (64'd1 << CNT_WIDTH) - 64'd1;

    logic [SET_SIZE-1:0]  hit_oh, cmd_v;
    logic                 found, kw_ok, accept, ack_d, err_d, ack_q, err_q;
    op_e                  op;
    logic [SET_WIDTH-1:0] val;
    logic [CNT_WIDTH-1:0] cnt;

    always_comb begin
        hit_oh = '0;
        found  = 1'b0;
        for (int i = 0; i < SET_SIZE; i++)
            if (!found && i_args[1] == i_set_alias[i]) begin
                hit_oh[i] = 1'b1;
                found     = 1'b1;
            end
        kw_ok  = i_args[0] == KW_SET || i_args[0] == KW_SET_DELAY || i_args[0] == KW_PULSE;
        op     = i_args[0] == KW_PULSE ? OP_PULSE : i_args[0] == KW_SET_DELAY ? OP_DELAY : OP_SET;
        accept = i_set_sel && i_args_valid;
        ack_d  = accept && found && kw_ok;
        err_d  = accept && !(found && kw_ok);
        cmd_v  = ack_d ? hit_oh : '0;
        val    = SET_WIDTH'(parse_value(i_args[2]));
        cnt    = CNT_WIDTH'(parse_dec_sat(i_args[3], CNT_MAX));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ack_q <= ack_d;
            err_q <= err_d;
        end
    end

    assign o_ack = ack_q;
    assign o_err = err_q;

    for (genvar g = 0; g < SET_SIZE; g++) begin : g_ch
        set_injector_channel #(
            .SET_WIDTH(SET_WIDTH),
            .CNT_WIDTH(CNT_WIDTH),
            .RST_VAL  (RST_VAL)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .i_cmd (cmd_v[g]),
            .i_op  (op),
            .i_val (val),
            .i_cnt (cnt),
            .o_val (o_set[g]),
            .o_busy(o_busy[g])
        );
    end

`ifdef SET_TIMED_INJECTOR_LOG_EN
    string                last_cmd [SET_SIZE];
    logic [SET_WIDTH-1:0] prev [SET_SIZE];
    always @(posedge clk) begin
        for (int i = 0; i < SET_SIZE; i++) begin
            if (o_set[i] !== prev[i])
                $display("%0t %s %s 0x%0h", $time, i_set_alias[i], last_cmd[i], o_set[i]);
            prev[i] <= o_set[i];
            if (cmd_v[i]) last_cmd[i] <= i_args[0];
        end
        if (err_d && rst_n)
            $display("%0t ERR %s %s %s", $time, i_args[1], i_args[0], i_args[2]);
    end
`endif

endmodule

// File: tb/tb_set_timed_injector.sv
// tb_set_timed_injector: vector table plus timed sequences; ack/err expectations flow
// through a scoreboard queue from drive to compare.
module tb_set_timed_injector;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        valid = 1'b0;
    string       aliases [5];
    string       args [5];
    logic [31:0] o_set [5];
    logic [4:0]  busy;
    logic        ack, err;
    logic [7:0]  o_set8 [5];
    logic [4:0]  busy8;
    logic        ack8, err8;
    int          checks = 0;
    int          errors = 0;

    typedef struct { logic ack; logic err; } exp_t;
    exp_t sb [$];

    typedef struct {
        string c; string a; string v; string n;
        bit ea; int ch; logic [31:0] ev;
    } vec_t;
    vec_t tv [9];

    always #5 clk = ~clk;

    set_timed_injector dut (
        .clk(clk), .rst_n(rst_n), .i_set_alias(aliases), .i_set_sel(sel),
        .i_args_valid(valid), .i_args(args), .o_set(o_set), .o_busy(busy),
        .o_ack(ack), .o_err(err)
    );

    set_timed_injector #(.SET_WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .i_set_alias(aliases), .i_set_sel(sel),
        .i_args_valid(valid), .i_args(args), .o_set(o_set8), .o_busy(busy8),
        .o_ack(ack8), .o_err(err8)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic issue(input string c, input string a, input string v, input string n, input bit ea);
        exp_t e;
        @(negedge clk);
        args[0] = c; args[1] = a; args[2] = v; args[3] = n;
        sel = 1'b1; valid = 1'b1;
        sb.push_back('{ea, !ea});
        @(posedge clk);
        #1;
        sel = 1'b0; valid = 1'b0;
        e = sb.pop_front();
        chk({c, " ", a, " ack"}, {31'd0, ack}, {31'd0, e.ack});
        chk({c, " ", a, " err"}, {31'd0, err}, {31'd0, e.err});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        aliases = '{"A", "B", "C", "D", "E"};
        foreach (args[i]) args[i] = "";
        tv[0] = '{"SET",       "A", "0x1F",       "",  1, 0, 32'h1F};
        tv[1] = '{"SET",       "B", "255",        "",  1, 1, 32'd255};
        tv[2] = '{"SET",       "C", "0Xab",       "",  1, 2, 32'hAB};
        tv[3] = '{"SET",       "Z", "1",          "",  0, 0, 32'h1F};
        tv[4] = '{"FOO",       "A", "1",          "",  0, 0, 32'h1F};
        tv[5] = '{"SET_DELAY", "E", "77",         "0", 1, 4, 32'd77};
        tv[6] = '{"PULSE",     "D", "9",          "0", 1, 3, 32'd0};
        tv[7] = '{"SET",       "A", "4294967297", "",  1, 0, 32'd1};
        tv[8] = '{"SET",       "A", "0x1234",     "",  1, 0, 32'h1234};

        #12;
        for (int i = 0; i < 5; i++) chk($sformatf("rst o_set%0d", i), o_set[i], 32'd0);
        chk("rst busy", {27'd0, busy}, 32'd0);
        chk("rst ack", {31'd0, ack}, 32'd0);
        chk("rst err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            issue(tv[i].c, tv[i].a, tv[i].v, tv[i].n, tv[i].ea);
            chk($sformatf("vec%0d o_set%0d", i, tv[i].ch), o_set[tv[i].ch], tv[i].ev);
        end
        chk("w8 trunc", {24'd0, o_set8[0]}, 32'h34);
        chk("table busy", {27'd0, busy}, 32'd0);

        @(negedge clk);
        args[0] = "SET"; args[1] = "A"; args[2] = "5"; valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        chk("nosel ack", {31'd0, ack}, 32'd0);
        chk("nosel o_set0", o_set[0], 32'h1234);

        issue("SET_DELAY", "B", "100", "10", 1);
        chk("dly busy0", {31'd0, busy[1]}, 32'd1);
        chk("dly old0", o_set[1], 32'd255);
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) chk("ack pulse", {31'd0, ack}, 32'd0);
            if (n < 10) begin
                chk($sformatf("dly busy%0d", n), {31'd0, busy[1]}, 32'd1);
                chk($sformatf("dly old%0d", n), o_set[1], 32'd255);
            end else begin
                chk("dly new", o_set[1], 32'd100);
                chk("dly idle", {31'd0, busy[1]}, 32'd0);
            end
        end

        issue("SET", "C", "5", "", 1);
        issue("PULSE", "C", "0xFF", "3", 1);
        chk("pls on", o_set[2], 32'hFF);
        chk("pls busy", {31'd0, busy[2]}, 32'd1);
        issue("SET", "A", "7", "", 1);
        chk("pls other", o_set[0], 32'd7);
        chk("pls on1", o_set[2], 32'hFF);
        @(posedge clk);
        #1;
        chk("pls on2", o_set[2], 32'hFF);
        @(posedge clk);
        #1;
        chk("pls restore", o_set[2], 32'd5);
        chk("pls idle", {31'd0, busy[2]}, 32'd0);
        chk("pls other2", o_set[0], 32'd7);

        issue("PULSE", "D", "9", "50", 1);
        chk("abort on", o_set[3], 32'd9);
        repeat (19) @(posedge clk);
        issue("SET", "D", "2", "", 1);
        chk("abort new", o_set[3], 32'd2);
        chk("abort idle", {31'd0, busy[3]}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("abort no restore", o_set[3], 32'd2);

        issue("SET_DELAY", "B", "50", "2", 1);
        @(posedge clk);
        issue("SET", "B", "60", "", 1);
        chk("race new", o_set[1], 32'd60);
        chk("race idle", {31'd0, busy[1]}, 32'd0);
        @(posedge clk);
        #1;
        chk("race hold", o_set[1], 32'd60);

        issue("SET_DELAY", "E", "3", "20", 1);
        chk("rst busy pre", {31'd0, busy[4]}, 32'd1);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async o_set4", o_set[4], 32'd0);
        chk("async o_set0", o_set[0], 32'd0);
        chk("async busy", {27'd0, busy}, 32'd0);
        args[0] = "SET"; args[1] = "A"; args[2] = "9"; args[3] = "";
        sel = 1'b1; valid = 1'b1;
        @(posedge clk);
        #1;
        sel = 1'b0; valid = 1'b0;
        chk("inrst ack", {31'd0, ack}, 32'd0);
        chk("inrst o_set0", o_set[0], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        chk("post rst o_set4", o_set[4], 32'd0);
        chk("post rst busy", {27'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
